// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry decoupling queue between instruction fetch and
// decode. Valid/ready handshake on both sides, single-cycle flush, and a NOP
// presented to decode whenever the queue is empty. All outputs are decoded
// from registered state only; there is no input-to-output combinational path.
module if_id_queue #(
    parameter int          XLEN  = 32,
    parameter int          DEPTH = 2,
    parameter logic [31:0] NOP   = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [31:0]                in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] EMPTY_CNT = '0;

    // Storage is never reset: the empty gating on the outputs hides whatever
    // stale contents remain after reset or flush.
    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Occupancy flags and the two handshake qualifiers. Flush suppresses both
    // sides: an offered beat is dropped and the head is not counted consumed.
    always_comb begin
        full  = (count_q == FULL_CNT);
        empty = (count_q == EMPTY_CNT);
        push  = in_valid & ~full & ~flush;
        pop   = ~empty & out_ready & ~flush;
    end

    // Output decode from registers only; ready ignores out_ready, so a full
    // queue never accepts in the same cycle it pops.
    always_comb begin
        in_ready  = ~full;
        out_valid = ~empty;
        out_pc    = '0;
        out_instr = NOP;
        if (!empty) begin
            out_pc    = pc_mem[rd_ptr];
            out_instr = instr_mem[rd_ptr];
        end
        count = count_q;
    end

    // Control state: reset over flush over push/pop. Pointers wrap by natural
    // overflow since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry write on an accepted beat; no bypass, so the beat shows up at the
    // output one cycle later at the earliest.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

endmodule
